noise_estimation: RTL and testbench
===================================

NOISE_ESTIMATION -- requirements
Module: noise_estimation

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the incoming read-data word.
REQ-002 Parameter BLOCK_SIZE, default 4, block edge in pixels; power of two in {2,4,8}; N = BLOCK_SIZE*BLOCK_SIZE, L = log2(N).
REQ-003 Reset is synchronous and active-high, and the block has one clock: clk, rst.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port frame_height  input  16  frame rows, sampled on start_of_frame.
REQ-007 Port frame_width  input  16  frame columns, sampled on start_of_frame.
REQ-008 Port start_of_frame  input  1  one-cycle pulse that opens a new frame.
REQ-009 Port noise_estimation_en  input  1  pixel-window enable driven by the block-order memory reader.
REQ-010 Port data_in  input  DATA_WIDTH  read data; pixel = data_in[7:0], unsigned.
REQ-011 Port valid_in  input  1  data_in valid (AXI rvalid & rready).
REQ-012 Port estimated_noise  output  16  frame mean of block variances.
REQ-013 Port min_block_variance  output  16  smallest block variance in the frame.
REQ-014 Port estimation_done  output  1  one-cycle pulse; both results are valid.
REQ-015 Port busy  output  1  high from start_of_frame until estimation_done.

Function
REQ-016 States: IDLE, ACCUM, DIVIDE, DONE.
REQ-017 Transitions:
- IDLE->ACCUM on start_of_frame.
- ACCUM->DIVIDE one cycle after the last block's variance is folded in.
- DIVIDE->DONE after 32 iterations.
- DONE->IDLE after one cycle.
REQ-018 start_of_frame in any state forces ACCUM and clears pixel/block counters, accumulators and min register (aborts any frame in progress); outputs keep their previous values.
REQ-019 On start_of_frame, total_blocks = (frame_height*frame_width) >> L is latched as a 32-bit value.
REQ-020 A pixel is accepted on each edge with valid_in & noise_estimation_en in ACCUM, including the start_of_frame cycle itself; pixels in IDLE/DIVIDE/DONE are dropped.
REQ-021 Per block: sum (L+8 bits) += p and sumsq (L+16 bits) += p*p; pixel counter wraps at N.
REQ-022 On the N-th pixel, sum/sumsq are snapshotted to a calc stage and cleared in the same cycle; the next block's first pixel is accepted on the following cycle with no stall.
REQ-023 Calc stage, one cycle later: var = ((sumsq << L) - sum*sum) >> (2L), truncated, unsigned, result at most 16 bits.
REQ-024 Calc stage also adds var to a 32-bit var_acc, increments blocks_done, and sets min = var if var < min (min reset value 16'hFFFF at frame start).
REQ-025 When blocks_done reaches total_blocks, a 32-cycle restoring divide computes var_acc / total_blocks; the quotient's low 16 bits go to estimated_noise.
REQ-026 estimation_done pulses exactly 34 edges after the edge that accepts the final pixel; estimated_noise and min_block_variance update on the same edge.
REQ-027 If total_blocks == 0: go ACCUM->DIVIDE->DONE immediately, with estimated_noise = 0 and min_block_variance = 0.
REQ-028 Partial-block pixels left over when a start_of_frame arrives are discarded.

Reset
REQ-029 On rst: state IDLE; estimated_noise = 0, min_block_variance = 0, estimation_done = 0, busy = 0; all counters and accumulators = 0.
REQ-030 rst has priority over start_of_frame and aborts any divide with no done pulse.

Verification
REQ-031 8x8 frame, BLOCK_SIZE 4, all 64 pixels = 100 -> one done pulse, estimated_noise = 0, min_block_variance = 0.
REQ-032 8x8 frame; block 0 = eight 0s and eight 255s, blocks 1-3 constant 50 -> block vars 16256/0/0/0; estimated_noise = 4064, min_block_variance = 0.
REQ-033 4x4 frame with ramp 0..15, continuous valid -> var = 21; done 34 cycles after the 16th pixel; both outputs = 21.
REQ-034 start_of_frame after 20 pixels of an 8x8 frame, then a clean 8x8 constant frame -> exactly one done pulse, estimated_noise = 0; the first frame contributes nothing.
REQ-035 rst during DIVIDE -> no done pulse, all outputs 0, busy 0; a following frame completes normally.
REQ-036 valid_in high with noise_estimation_en low, or during DIVIDE -> pixels ignored; results are identical to the gap-free run.

Source files
------------

// File: rtl/noise_estimation_if.sv
// Pixel stream, frame geometry and noise results exchanged between the block-order reader and the estimator.
// master drives pixels and frame control; slave returns the per-frame results.
interface noise_estimation_if #(
    parameter int DATA_WIDTH = 32
);
    logic [15:0]           frame_height;
    logic [15:0]           frame_width;
    logic                  start_of_frame;
    logic                  noise_estimation_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic [15:0]           estimated_noise;
    logic [15:0]           min_block_variance;
    logic                  estimation_done;
    logic                  busy;

    modport master (
        output frame_height, frame_width, start_of_frame, noise_estimation_en, data_in, valid_in,
        input  estimated_noise, min_block_variance, estimation_done, busy
    );

    modport slave (
        input  frame_height, frame_width, start_of_frame, noise_estimation_en, data_in, valid_in,
        output estimated_noise, min_block_variance, estimation_done, busy
    );
endinterface

// File: rtl/noise_estimation.sv
// Per-block pixel variance, frame mean (restoring divide) and frame minimum of block variances.
// Done pulses 34 edges after the final pixel; no backpressure, pixels outside ACCUM are dropped.
module noise_estimation #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 4
) (
    input logic               clk,
    input logic               rst,
    noise_estimation_if.slave bus
);
    localparam int N  = BLOCK_SIZE * BLOCK_SIZE;
    localparam int L  = $clog2(N);
    localparam int VW = 2 * L + 16;

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;
    state_t state;

    logic [L-1:0]  pix_cnt;
    logic [L+7:0]  sum, calc_sum, sum_nx;
    logic [L+15:0] sumsq, calc_sumsq, sumsq_nx;
    logic          calc_vld;
    logic [31:0]   total_blocks, blocks_done, var_acc;
    logic [15:0]   min_var;
    logic [31:0]   div_rem, div_quo, rem_nx, quo_nx;
    logic [4:0]    div_cnt;
    logic [15:0]   est_q, min_q;
    logic          done_q, busy_q;

    logic [7:0]    pix;
    logic [15:0]   pix_sq;
    logic          accept;
    logic [VW-1:0] sumsq_sh, sum_sq, var_full;
    logic [15:0]   blk_var;
    logic [31:0]   area;
    logic [32:0]   div_shift, div_trial;
    logic          unused_bits;

    assign pix      = bus.data_in[7:0];
    assign pix_sq   = {8'd0, pix} * {8'd0, pix};
    // The start_of_frame cycle itself carries the first pixel of the new frame.
    assign accept   = bus.valid_in & bus.noise_estimation_en & (bus.start_of_frame | (state == ACCUM));
    assign sum_nx   = sum + {{L{1'b0}}, pix};
    assign sumsq_nx = sumsq + {{L{1'b0}}, pix_sq};

    assign sumsq_sh = {{L{1'b0}}, calc_sumsq} << L;
    assign sum_sq   = {{(L+8){1'b0}}, calc_sum} * {{(L+8){1'b0}}, calc_sum};
    assign var_full = sumsq_sh - sum_sq;
    assign blk_var  = var_full[VW-1:2*L];

    assign area      = {16'd0, bus.frame_height} * {16'd0, bus.frame_width};
    assign div_shift = {div_rem, div_quo[31]};
    assign div_trial = div_shift - {1'b0, total_blocks};
    assign rem_nx    = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
    assign quo_nx    = {div_quo[30:0], ~div_trial[32]};

    assign unused_bits = ^{bus.data_in[DATA_WIDTH-1:8], var_full[2*L-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pix_cnt      <= '0;
            sum          <= '0;
            sumsq        <= '0;
            calc_sum     <= '0;
            calc_sumsq   <= '0;
            calc_vld     <= 1'b0;
            total_blocks <= '0;
            blocks_done  <= '0;
            var_acc      <= '0;
            min_var      <= '0;
            div_rem      <= '0;
            div_quo      <= '0;
            div_cnt      <= '0;
            est_q        <= '0;
            min_q        <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else if (bus.start_of_frame) begin
            state        <= ACCUM;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            total_blocks <= area >> L;
            blocks_done  <= '0;
            var_acc      <= '0;
            min_var      <= 16'hFFFF;
            calc_vld     <= 1'b0;
            div_cnt      <= '0;
            if (accept) begin
                pix_cnt <= L'(1);
                sum     <= {{L{1'b0}}, pix};
                sumsq   <= {{L{1'b0}}, pix_sq};
            end else begin
                pix_cnt <= '0;
                sum     <= '0;
                sumsq   <= '0;
            end
        end else begin
            done_q   <= 1'b0;
            calc_vld <= 1'b0;
            if (accept) begin
                if (pix_cnt == L'(N - 1)) begin
                    calc_vld   <= 1'b1;
                    calc_sum   <= sum_nx;
                    calc_sumsq <= sumsq_nx;
                    sum        <= '0;
                    sumsq      <= '0;
                end else begin
                    sum   <= sum_nx;
                    sumsq <= sumsq_nx;
                end
                pix_cnt <= pix_cnt + L'(1);
            end
            if (calc_vld) begin
                var_acc     <= var_acc + {16'd0, blk_var};
                blocks_done <= blocks_done + 32'd1;
                if (blk_var < min_var) min_var <= blk_var;
            end
            case (state)
                ACCUM: begin
                    if (blocks_done == total_blocks) begin
                        state   <= DIVIDE;
                        div_rem <= '0;
                        div_quo <= var_acc;
                        div_cnt <= '0;
                    end
                end
                DIVIDE: begin
                    if (total_blocks == 32'd0) begin
                        est_q  <= '0;
                        min_q  <= '0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else begin
                        div_rem <= rem_nx;
                        div_quo <= quo_nx;
                        div_cnt <= div_cnt + 5'd1;
                        if (div_cnt == 5'd31) begin
                            est_q  <= quo_nx[15:0];
                            min_q  <= min_var;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: ;
            endcase
        end
    end

    assign bus.estimated_noise    = est_q;
    assign bus.min_block_variance = min_q;
    assign bus.estimation_done    = done_q;
    assign bus.busy               = busy_q;
endmodule

// File: tb/tb_noise_estimation.sv
// Directed frame vectors with hand-computed block variances, plus abort, reset and gap sequences.
module tb_noise_estimation;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noise_estimation_if #(.DATA_WIDTH(32)) bus();

    noise_estimation #(.DATA_WIDTH(32), .BLOCK_SIZE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int h;
        int w;
        int pat;
        bit gaps;
        int exp_noise;
        int exp_min;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    always @(negedge clk) if (bus.estimation_done === 1'b1) done_cnt++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit sof, bit v, bit en, logic [7:0] d);
        bus.start_of_frame      = sof;
        bus.valid_in            = v;
        bus.noise_estimation_en = en;
        bus.data_in             = {24'h5A5A5A, d};
    endtask

    function automatic logic [7:0] pix_val(int pat, int blk, int idx);
        case (pat)
            0:       return 8'd100;
            1:       return (blk == 0) ? ((idx < 8) ? 8'd0 : 8'd255) : 8'd50;
            2:       return 8'(idx);
            default: return (blk == 0) ? 8'(idx) : (((idx % 2) == 0) ? 8'd0 : 8'd4);
        endcase
    endfunction

    task automatic feed_frame(int h, int w, int pat, bit gaps, int max_pix, string tag);
        int  nblk;
        int  cnt;
        bit  first;
        nblk  = (h * w) / 16;
        cnt   = 0;
        first = 1'b1;
        bus.frame_height = 16'(h);
        bus.frame_width  = 16'(w);
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 16; i++) begin
                if (cnt < max_pix) begin
                    if (gaps && !first && (i % 3) == 1) begin
                        drive(1'b0, 1'b1, 1'b0, 8'hFF);
                        cyc();
                        drive(1'b0, 1'b0, 1'b1, 8'hEE);
                        cyc();
                    end
                    drive(first, 1'b1, 1'b1, pix_val(pat, b, i));
                    cyc();
                    if (first) check({tag, "_busy_after_sof"}, 32'(bus.busy), 32'd1);
                    first = 1'b0;
                    cnt++;
                end
            end
        end
        if (first) begin
            drive(1'b1, 1'b0, 1'b0, 8'd0);
            cyc();
        end
        // In gap mode keep offering junk pixels while the divider runs.
        drive(1'b0, gaps, gaps, 8'hC3);
    endtask

    task automatic finish_frame(int exp_noise, int exp_min, bit chk_lat, string tag);
        int edges;
        bit seen;
        int d0;
        edges = 0;
        seen  = 1'b0;
        while (edges < 200 && !seen) begin
            cyc();
            edges++;
            if (bus.estimation_done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (chk_lat) check({tag, "_latency"}, 32'(edges), 32'd34);
        check({tag, "_noise"}, 32'(bus.estimated_noise), 32'(exp_noise));
        check({tag, "_min"}, 32'(bus.min_block_variance), 32'(exp_min));
        cyc();
        check({tag, "_done_width"}, 32'(bus.estimation_done), 32'd0);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        d0 = done_cnt;
        repeat (40) cyc();
        check({tag, "_extra_done"}, 32'(done_cnt - d0), 32'd0);
    endtask

    initial begin
        int d0;
        vecs[0] = '{8, 8, 0, 1'b0, 0, 0};
        vecs[1] = '{8, 8, 1, 1'b0, 4064, 0};
        vecs[2] = '{4, 4, 2, 1'b0, 21, 21};
        vecs[3] = '{2, 4, 0, 1'b0, 0, 0};
        vecs[4] = '{8, 8, 2, 1'b1, 21, 21};
        vecs[5] = '{8, 8, 1, 1'b1, 4064, 0};
        vecs[6] = '{4, 8, 3, 1'b0, 12, 4};
        vecs[7] = '{8, 4, 3, 1'b1, 12, 4};

        rst = 1'b1;
        bus.frame_height = '0;
        bus.frame_width  = '0;
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("reset_noise", 32'(bus.estimated_noise), 32'd0);
        check("reset_min", 32'(bus.min_block_variance), 32'd0);
        check("reset_done", 32'(bus.estimation_done), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);

        for (int k = 0; k < 8; k++) begin
            string tag;
            tag = $sformatf("v%0d", k);
            feed_frame(vecs[k].h, vecs[k].w, vecs[k].pat, vecs[k].gaps, 1024, tag);
            finish_frame(vecs[k].exp_noise, vecs[k].exp_min, (vecs[k].h * vecs[k].w) >= 16, tag);
        end

        // Abort a frame after 20 pixels; previous results must survive the restart.
        d0 = done_cnt;
        feed_frame(8, 8, 1, 1'b0, 20, "abort");
        feed_frame(8, 8, 0, 1'b0, 1, "restart");
        check("sof_keeps_noise", 32'(bus.estimated_noise), 32'd12);
        check("sof_keeps_min", 32'(bus.min_block_variance), 32'd4);
        feed_frame(8, 8, 0, 1'b0, 1024, "clean");
        finish_frame(0, 0, 1'b1, "clean");
        check("abort_one_done", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of the divide.
        feed_frame(4, 8, 3, 1'b0, 1024, "pre_rst");
        finish_frame(12, 4, 1'b1, "pre_rst");
        feed_frame(8, 8, 1, 1'b0, 1024, "div_rst");
        repeat (10) cyc();
        d0 = done_cnt;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_div_noise", 32'(bus.estimated_noise), 32'd0);
        check("rst_div_min", 32'(bus.min_block_variance), 32'd0);
        check("rst_div_busy", 32'(bus.busy), 32'd0);
        repeat (50) cyc();
        check("rst_div_no_done", 32'(done_cnt - d0), 32'd0);
        feed_frame(4, 4, 2, 1'b0, 1024, "post_rst");
        finish_frame(21, 21, 1'b1, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
